// File: rtl/fixed_round_pkg.sv
// Shared constants for the fixed-point requantising skid buffer: rounding modes and skid FSM states.
package fixed_round_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // EMPTY: nothing held; ONE: output register full; TWO: output and skid both full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fixed_round_sat_lane.sv
// Combinational requantiser for one signed lane: shift to the output fraction width, optional
// round-half-up, then clamp to the output range with a saturation flag.
module fixed_round_sat_lane
    import fixed_round_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int IN_FRAC    = 4,
    parameter int OUT_W      = 4,
    parameter int OUT_FRAC   = 2,
    parameter int ROUND_MODE = ROUND_HALF_UP
) (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             sat
);

    localparam int S  = IN_FRAC - OUT_FRAC;
    localparam int AS = (S < 0) ? -S : S;
    // Two guard bits above the shifted magnitude so the rounding add can never wrap.
    localparam int W  = IN_W + AS + 2;

    localparam logic signed [W-1:0] MAX_V = W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [W-1:0] MIN_V = ~MAX_V;

    logic signed [W-1:0] xe;
    logic signed [W-1:0] yw;

    assign xe = {{(W - IN_W){x[IN_W-1]}}, x};

    generate
        if (S > 0) begin : g_right
            localparam logic signed [W-1:0] HALF =
                (ROUND_MODE == ROUND_HALF_UP) ? (W'(1) << (S - 1)) : '0;
            logic signed [W-1:0] t;
            assign t  = xe + HALF;
            assign yw = t >>> S;
        end else begin : g_left
            assign yw = xe <<< AS;
        end
    endgenerate

    always_comb begin
        y   = yw[OUT_W-1:0];
        sat = 1'b0;
        if (yw > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            sat = 1'b1;
        end else if (yw < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_round_sat_buffer.sv
// Requantise N signed lanes on the input side and hold them in a two-entry skid buffer with a
// registered input ready. Optional saturation counter enabled by FIXED_ROUND_SAT_STATS_EN.
module fixed_round_sat_buffer
    import fixed_round_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 4,
    parameter int DATA_OUT_0_PRECISION_1      = 2,
    parameter int ROUND_MODE                  = ROUND_HALF_UP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                                 data_in_0,
    input  logic                 data_in_0_valid,
    output logic                 data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                                 data_out_0,
    output logic                 data_out_0_valid,
    input  logic                 data_out_0_ready,
`ifdef FIXED_ROUND_SAT_STATS_EN
    output logic [15:0]          sat_count,
`endif
    output logic [1:0]           fsm_state
);

    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;

    // Handshake: a beat moves on a rising edge where valid && ready; ready never depends
    // combinationally on valid, and data_out_0 stays put while valid && !ready.
    skid_state_e          state, state_next;
    logic                 ready_q;
    logic [N*OUT_W-1:0]   q_data, out_q, skid_q;
    logic [N-1:0]         sat_flags;
    logic                 accept, drain;
    logic                 load_out, load_skid, out_from_skid;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_round_sat_lane #(
            .IN_W      (IN_W),
            .IN_FRAC   (DATA_IN_0_PRECISION_1),
            .OUT_W     (OUT_W),
            .OUT_FRAC  (DATA_OUT_0_PRECISION_1),
            .ROUND_MODE(ROUND_MODE)
        ) u_lane (
            .x  (data_in_0[i*IN_W +: IN_W]),
            .y  (q_data[i*OUT_W +: OUT_W]),
            .sat(sat_flags[i])
        );
    end

    assign accept           = data_in_0_valid && ready_q;
    assign drain            = data_out_0_valid && data_out_0_ready;
    assign data_in_0_ready  = ready_q;
    assign data_out_0_valid = (state != EMPTY);
    assign data_out_0       = out_q;
    assign fsm_state        = state;

    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_next = ONE;
                load_out   = 1'b1;
            end
            ONE: begin
                if (accept && !drain) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (drain && !accept) begin
                    state_next = EMPTY;
                end else if (drain && accept) begin
                    load_out = 1'b1;
                end
            end
            TWO: if (drain) begin
                state_next    = ONE;
                load_out      = 1'b1;
                out_from_skid = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
            if (load_out)  out_q  <= out_from_skid ? skid_q : q_data;
            if (load_skid) skid_q <= q_data;
        end
    end

`ifdef FIXED_ROUND_SAT_STATS_EN
    logic [16:0] sat_pop;
    logic [16:0] sat_sum;

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < N; i++) sat_pop = sat_pop + 17'(sat_flags[i]);
        sat_sum = {1'b0, sat_count} + sat_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
        end else if (accept) begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_flags;
`endif

endmodule
